// File: rtl/uart_pkg.sv
// Shared UART constants, frame-length helper and arbiter state encoding.
// UART_ARB_GUARD_EN adds one idle bit time after each stop bit.
package uart_pkg;

   localparam int DEF_UART_BPS = 9600;
   localparam int DEF_CLK_FREQ = 50_000_000;

   // Bit times per frame: start + 8 data + stop, plus optional guard bit
   function automatic int frame_bits();
`ifdef UART_ARB_GUARD_EN
      return 11;
`else
      return 10;
`endif
   endfunction

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr_i,
// wrapping N-1 -> 0. ptr_i must be below N.
module rr_pick #(
   parameter int N   = 2,
   parameter int IDW = 3
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic [IDW-1:0] idx_o,
   output logic           valid_o
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [IDW:0]   off;
   logic [IDW:0]   sum;

   // Rotate so the pointer position lands at bit 0, then take the lowest set bit
   assign dbl = {req_i, req_i};
   assign rot = N'(dbl >> ptr_i);

   always_comb begin
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) off = (IDW+1)'(i);
      end
   end

   assign sum     = {1'b0, ptr_i} + off;
   assign idx_o   = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : sum[IDW-1:0];
   assign valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte sources.
// Frame hold-off is 10 bit times, or 11 when UART_ARB_GUARD_EN is defined.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int UART_BPS = DEF_UART_BPS,
   parameter int CLK_FREQ = DEF_CLK_FREQ
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*8-1:0] req_data,
   output logic [N_REQ-1:0]   ack,
   output logic [7:0]         pi_data,
   output logic               pi_flag,
   output logic               busy,
   output logic [2:0]         grant_id
);

   localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int FRAME_CYC    = frame_bits() * BAUD_CNT_MAX;
   localparam int CNT_W        = $clog2(FRAME_CYC + BAUD_CNT_MAX);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       gid_q, gid_d;
   logic [7:0]       data_q, data_d;
   logic [2:0]       win_idx;
   logic             win_vld;

   rr_pick #(.N(N_REQ), .IDW(3)) u_rr_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .idx_o   (win_idx),
      .valid_o (win_vld)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gid_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            // req_data is captured only here; later drops of req cannot cancel
            if (win_vld) begin
               gid_d   = win_idx;
               data_d  = 8'(req_data >> {win_idx, 3'b000});
               state_d = SEND;
            end
         end
         SEND: begin
            ptr_d   = (gid_q == 3'(N_REQ - 1)) ? 3'd0 : gid_q + 3'd1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(FRAME_CYC - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pi_flag = (state_q == SEND);
      busy    = (state_q != IDLE);
      ack     = (state_q == SEND) ? (N_REQ'(1) << gid_q) : '0;
   end

   assign pi_data  = data_q;
   assign grant_id = gid_q;

endmodule
